// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver.
//   - 3-bit state encodings for the transmit FSM
//   - frame constants: default payload width, idle and start line levels
// No ports; imported by uart_tx and the matching receiver.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SYNC   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    typedef enum logic [2:0] {
        TX_IDLE   = ST_IDLE,
        TX_SYNC   = ST_SYNC,
        TX_START  = ST_START,
        TX_DATA   = ST_DATA,
        TX_PARITY = ST_PARITY,
        TX_STOP   = ST_STOP
    } tx_state_e;

    localparam int   DEFAULT_DATA_BITS = 8;
    localparam logic LINE_IDLE         = 1'b1;
    localparam logic LINE_START        = 1'b0;

endpackage

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// Serial UART transmitter. Accepts one parallel word per handshake and sends
// start bit, LSB-first data, optional parity and 1 or 2 stop bits. Every bit
// boundary is set by the shared baud generator's single-cycle tick.
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   tick      in   one-cycle bit-boundary pulse from the baud generator
//   tx_start  in   request to send tx_data (only looked at while idle)
//   tx_data   in   payload, captured on the accepting edge
//   tx        out  serial line, idle high, registered
//   tx_busy   out  high from the cycle after acceptance until frame end
//   tx_done   out  one-cycle pulse on the final stop-bit tick
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [2:0] LAST_DATA  = 3'(DATA_BITS - 1);
    localparam logic       PARITY_INV = (PARITY_ODD != 0);

    tx_state_e            state_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] shreg_d;
    logic [2:0]           cnt_q;
    logic                 parity_q;
    logic                 parity_d;
    logic                 stop_q;
    logic                 stop_last;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;

    // Next values for the data phase: the bit leaving the shifter is folded
    // into the running parity, and the new LSB is the next bit on the line.
    assign shreg_d  = shreg_q >> 1;
    assign parity_d = parity_q ^ shreg_q[0];

    // With a single stop bit the first stop tick already ends the frame.
    assign stop_last = (STOP_BITS == 2) ? stop_q : 1'b1;

    // Transmit FSM. The line value is registered here so tx only moves on
    // tick edges; SYNC exists so the start bit always gets a full tick period
    // no matter where in the tick phase the request arrived.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= TX_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
            stop_q   <= 1'b0;
            tx_q     <= LINE_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                TX_IDLE: begin
                    tx_q <= LINE_IDLE;
                    if (tx_start) begin
                        shreg_q  <= tx_data;
                        parity_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= TX_SYNC;
                    end
                end
                TX_SYNC: begin
                    if (tick) begin
                        tx_q    <= LINE_START;
                        state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        tx_q    <= shreg_q[0];
                        cnt_q   <= '0;
                        state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        parity_q <= parity_d;
                        shreg_q  <= shreg_d;
                        if (cnt_q == LAST_DATA) begin
                            stop_q <= 1'b0;
                            if (PARITY_EN != 0) begin
                                tx_q    <= parity_d ^ PARITY_INV;
                                state_q <= TX_PARITY;
                            end else begin
                                tx_q    <= LINE_IDLE;
                                state_q <= TX_STOP;
                            end
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                            tx_q  <= shreg_d[0];
                        end
                    end
                end
                TX_PARITY: begin
                    if (tick) begin
                        tx_q    <= LINE_IDLE;
                        stop_q  <= 1'b0;
                        state_q <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    tx_q <= LINE_IDLE;
                    if (tick) begin
                        if (stop_last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= TX_IDLE;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule
